// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (and, later, the receiver).
//   - parity mode constants PAR_NONE / PAR_EVEN / PAR_ODD
//   - transmitter FSM state encoding tx_state_t
//   - frame_bits(): number of bit periods in one frame
// Optional feature macro: UART_TX_BREAK_EN adds the ST_BREAK state.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Wide enough for a bit index up to 9 data bits and for the stop-bit count.
    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
`ifdef UART_TX_BREAK_EN
        ,
        ST_BREAK
`endif
    } tx_state_t;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and wraps, emitting a
// one-cycle tick in the cycle where the count equals CLK_DIV-1. A synchronous
// clear (priority over enable) restarts the bit period. The running count is
// exported so a user can act a fixed number of cycles before the tick.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clr_i   in   synchronous clear of the count
//   en_i    in   count enable
//   tick_o  out  high during the last cycle of each bit period
//   cnt_o   out  current count value
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_DIV = 868,
    parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && at_end;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter. One word is accepted per s_valid/s_ready
// handshake and sent as: start bit (0), DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits (1). Each bit lasts CLK_DIV clocks.
// Optional feature macro: UART_TX_BREAK_EN enables line-break generation via
// break_req; without it break_req is ignored.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   source has a word
//   s_ready    out  transmitter can accept a word (combinational from IDLE)
//   s_data     in   word to send, sampled only at the handshake
//   break_req  in   line-break request (UART_TX_BREAK_EN only)
//   tx         out  serial line, idle high (registered)
//   busy       out  frame or break in progress (registered)
//   done       out  one-cycle pulse at frame end (registered)
// ---------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 break_req,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Reject unsupported configurations at elaboration.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_t              state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   par_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   baud_tick;
    logic [CNT_W-1:0]       baud_cnt;
    logic                   baud_clr;
    logic                   baud_en;
    logic                   handshake;
    logic                   stop_exit;

    // The counter sits at zero throughout IDLE, so every frame or break starts
    // with a fresh bit period from the edge that leaves IDLE.
    assign baud_clr = (state_q == ST_IDLE);
    assign baud_en  = (state_q != ST_IDLE);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (baud_clr),
        .en_i   (baud_en),
        .tick_o (baud_tick),
        .cnt_o  (baud_cnt)
    );

`ifdef UART_TX_BREAK_EN
    logic brk_rel_q;

    // A pending break wins over a word, so do not offer a handshake meanwhile.
    assign s_ready = (state_q == ST_IDLE) && !break_req;
`else
    logic unused_break_req;

    assign unused_break_req = break_req;
    assign s_ready          = (state_q == ST_IDLE);
`endif

    assign handshake = s_valid && s_ready;

    // Parity bit value: even makes the count of ones even, odd inverts it.
    assign par_d = (PARITY == PAR_ODD) ? ~(^s_data) : (^s_data);

    // The last cycle of the final stop bit is spent in IDLE (tx is high there
    // too), so a word offered in that cycle starts its start bit exactly one
    // frame period after the previous handshake, with no idle gap on the line.
    assign stop_exit = (state_q == ST_STOP)
                    && (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1))
                    && (baud_cnt == CNT_W'(CLK_DIV - 2));

    // Transmitter FSM with registered tx/busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_rel_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state_q   <= ST_BREAK;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        brk_rel_q <= 1'b0;
                    end else
`endif
                    if (handshake) begin
                        shift_q   <= s_data;
                        par_q     <= par_d;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_PAR: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (stop_exit) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (baud_tick) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

`ifdef UART_TX_BREAK_EN
                // Low phase lasts whole bit periods while break_req is held
                // (at least one), then one bit period of high before IDLE.
                ST_BREAK: begin
                    if (baud_tick) begin
                        if (brk_rel_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else if (!break_req) begin
                            brk_rel_q <= 1'b1;
                            tx_q      <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Self-checking bench for uart_tx_frame. Four instances cover the parameter
// sets of interest (all CLK_DIV=4):
//   0: 8 data bits, even parity, 1 stop
//   1: 8 data bits, odd parity,  1 stop
//   2: 8 data bits, no parity,   1 stop
//   3: 7 data bits, even parity, 2 stops
// The expected line waveform is built from the frame layout (start, data LSB
// first, parity, stops) one bit slot per CLK_DIV cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int CLK_DIV = 4;
    localparam int NDUT    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sValid   [NDUT];
    logic [8:0] sData    [NDUT];
    logic       breakReq [NDUT];
    logic       sReady   [NDUT];
    logic       tx       [NDUT];
    logic       busy     [NDUT];
    logic       done     [NDUT];

    int cfgBits [NDUT] = '{8, 8, 8, 7};
    int cfgPar  [NDUT] = '{1, 2, 0, 1};
    int cfgStop [NDUT] = '{1, 1, 1, 2};

    int total = 0;
    int bad   = 0;

    logic unusedTbBits;
    assign unusedTbBits = ^{sData[0][8], sData[1][8], sData[2][8], sData[3][8:7]};

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutEven (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[0]), .s_ready(sReady[0]),
        .s_data(sData[0][7:0]), .break_req(breakReq[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutOdd (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[1]), .s_ready(sReady[1]),
        .s_data(sData[1][7:0]), .break_req(breakReq[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutNone (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[2]), .s_ready(sReady[2]),
        .s_data(sData[2][7:0]), .break_req(breakReq[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dutSeven (
        .clk(clk), .rst_n(rst_n), .s_valid(sValid[3]), .s_ready(sReady[3]),
        .s_data(sData[3][6:0]), .break_req(breakReq[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

    // Table record: which instance, the word, expected parity bit on the line
    // (ignored without parity) and expected cycles from handshake to done end.
    typedef struct {
        int         dut;
        logic [8:0] word;
        logic       expPar;
        int         expLen;
    } vec_t;

    vec_t vecs [6];

    // Reference model: parity bit from the count of ones in the data field.
    function automatic logic modelParity(int idx, logic [8:0] word);
        int ones = 0;
        for (int i = 0; i < cfgBits[idx]; i++) ones += int'(word[i]);
        if (cfgPar[idx] == 1) return logic'(ones % 2);
        return logic'((ones + 1) % 2);
    endfunction

    // Reference model: line level j cycles after the handshake edge.
    function automatic logic modelTx(int idx, logic [8:0] word, int j);
        int slot = j / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot <= cfgBits[idx]) return word[slot-1];
        if (cfgPar[idx] != 0 && slot == cfgBits[idx] + 1) return modelParity(idx, word);
        return 1'b1;
    endfunction

    function automatic int modelLen(int idx);
        return (1 + cfgBits[idx] + ((cfgPar[idx] != 0) ? 1 : 0) + cfgStop[idx]) * CLK_DIV;
    endfunction

    task automatic checkOutput(string name, logic actual, logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", name, actual, expected);
        end
    endtask

    task automatic checkCount(string name, int actual, int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // Wait (bounded) until instance idx offers s_ready; called #1 after an edge.
    task automatic waitReady(int idx, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (sReady[idx]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) checkCount($sformatf("ready timeout dut%0d", idx), 0, 1);
    endtask

    // Present a word, handshake on the next edge, then check the line and
    // status outputs every cycle of the frame. Returns at the frame's final
    // (IDLE) cycle so a held s_valid handshakes on the very next edge.
    task automatic applyStimulus(int idx, logic [8:0] word, bit holdValid, bit swapData,
                                 logic [8:0] newData, output int doneAt, output logic parSeen);
        int len = modelLen(idx);
        int parJ = (cfgBits[idx] + 1) * CLK_DIV + 1;
        doneAt  = -1;
        parSeen = 1'b0;
        sValid[idx] = 1'b1;
        sData[idx]  = word;
        @(posedge clk);
        #1;
        if (!holdValid) sValid[idx] = 1'b0;
        for (int j = 0; j < len; j++) begin
            if (swapData && j == 10) sData[idx] = newData;
            checkOutput($sformatf("tx d%0d j%0d", idx, j), tx[idx], modelTx(idx, word, j));
            checkOutput($sformatf("busy d%0d j%0d", idx, j), busy[idx], logic'(j < len - 1));
            checkOutput($sformatf("done d%0d j%0d", idx, j), done[idx], logic'(j == len - 1));
            checkOutput($sformatf("ready d%0d j%0d", idx, j), sReady[idx], logic'(j == len - 1));
            if (done[idx] && doneAt < 0) doneAt = j + 1;
            if (j == parJ) parSeen = tx[idx];
            if (j < len - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         ok;
        int         doneAt;
        logic       parSeen;
        int         doneCnt;
        int         idx;
        logic [8:0] word;

        vecs[0] = '{0, 9'h055, 1'b0, 44};
        vecs[1] = '{1, 9'h007, 1'b0, 44};
        vecs[2] = '{0, 9'h007, 1'b1, 44};
        vecs[3] = '{2, 9'h007, 1'b0, 40};
        vecs[4] = '{3, 9'h07F, 1'b1, 44};
        vecs[5] = '{1, 9'h000, 1'b1, 44};

        for (int i = 0; i < NDUT; i++) begin
            sValid[i]   = 1'b0;
            sData[i]    = '0;
            breakReq[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset tx d%0d", i), tx[i], 1'b1);
            checkOutput($sformatf("reset busy d%0d", i), busy[i], 1'b0);
            checkOutput($sformatf("reset done d%0d", i), done[i], 1'b0);
            checkOutput($sformatf("reset ready d%0d", i), sReady[i], 1'b1);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of single frames across the parameter sets.
        for (int v = 0; v < 6; v++) begin
            waitReady(vecs[v].dut, ok);
            if (ok) begin
                applyStimulus(vecs[v].dut, vecs[v].word, 1'b0, 1'b0, 9'h000, doneAt, parSeen);
                checkCount($sformatf("frame len vec%0d", v), doneAt, vecs[v].expLen);
                if (cfgPar[vecs[v].dut] != 0)
                    checkOutput($sformatf("parity vec%0d", v), parSeen, vecs[v].expPar);
            end
        end

        // Back-to-back: s_valid held, data changed mid-frame, no idle gap.
        repeat (3) @(posedge clk);
        #1;
        waitReady(0, ok);
        if (ok) begin
            applyStimulus(0, 9'h0A3, 1'b1, 1'b1, 9'h03C, doneAt, parSeen);
            applyStimulus(0, 9'h03C, 1'b0, 1'b0, 9'h000, doneAt, parSeen);
            checkCount("b2b second len", doneAt, 44);
        end

        // Asynchronous reset during data bit 3.
        waitReady(0, ok);
        if (ok) begin
            sValid[0] = 1'b1;
            sData[0]  = 9'h096;
            @(posedge clk);
            #1;
            sValid[0] = 1'b0;
            repeat (17) begin
                @(posedge clk);
                #1;
            end
            checkOutput("pre-rst tx", tx[0], modelTx(0, 9'h096, 17));
            #2 rst_n = 1'b0;
            #1;
            checkOutput("async rst tx", tx[0], 1'b1);
            checkOutput("async rst busy", busy[0], 1'b0);
            checkOutput("async rst done", done[0], 1'b0);
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            doneCnt = 0;
            repeat (60) begin
                @(posedge clk);
                #1;
                if (done[0]) doneCnt++;
            end
            checkCount("rst no done", doneCnt, 0);
            waitReady(0, ok);
            if (ok) begin
                applyStimulus(0, 9'h096, 1'b0, 1'b0, 9'h000, doneAt, parSeen);
                checkCount("post-rst len", doneAt, 44);
            end
        end

`ifdef UART_TX_BREAK_EN
        // Break requested for 2 cycles with a word also offered: break wins.
        waitReady(0, ok);
        if (ok) begin
            sValid[0]   = 1'b1;
            sData[0]    = 9'h0AA;
            breakReq[0] = 1'b1;
            @(posedge clk);
            #1;
            for (int j = 0; j <= 8; j++) begin
                checkOutput($sformatf("brk tx j%0d", j), tx[0], logic'(j >= 4));
                checkOutput($sformatf("brk busy j%0d", j), busy[0], logic'(j < 8));
                checkOutput($sformatf("brk ready j%0d", j), sReady[0], logic'(j == 8));
                checkOutput($sformatf("brk done j%0d", j), done[0], 1'b0);
                if (j == 1) breakReq[0] = 1'b0;
                if (j == 6) sValid[0] = 1'b0;
                if (j < 8) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
`endif

        // Randomised frames on random instances with random idle gaps.
        for (int r = 0; r < 24; r++) begin
            idx  = int'($urandom_range(0, NDUT - 1));
            word = 9'($urandom) & 9'((1 << cfgBits[idx]) - 1);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            waitReady(idx, ok);
            if (ok) begin
                applyStimulus(idx, word, 1'b0, 1'b0, 9'h000, doneAt, parSeen);
                checkCount($sformatf("rand len %0d", r), doneAt, modelLen(idx));
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
